// File: rtl/skolem_sweep_checker_pkg.sv
// Shared defaults and state encoding for the Skolem sweep checker.
package skolem_pkg;

  localparam int SKOLEM_NX = 5;
  localparam int SKOLEM_NY = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/skolem_sweep_checker_if.sv
// Bundle between the sweep checker and the Skolem function / phi predicate under test.
interface skolem_sweep_checker_if
  import skolem_pkg::*;
#(
  parameter int NX = SKOLEM_NX,
  parameter int NY = SKOLEM_NY
);

  logic          start;
  logic          abort;
  logic [NX-1:0] x_o;
  logic [NY-1:0] y_i;
  logic          phi_i;
  logic          busy;
  logic          done;
  logic          pass;
  logic [NX:0]   fail_count;
  logic          cex_valid;
  logic [NX-1:0] cex_x;
  logic [NY-1:0] cex_y;

  // Test top: launches sweeps and supplies the Skolem outputs and phi verdict.
  modport master (
    output start, abort, y_i, phi_i,
    input  x_o, busy, done, pass, fail_count, cex_valid, cex_x, cex_y
  );

  // Checker: walks x_o through every input vector and grades phi_i.
  modport slave (
    input  start, abort, y_i, phi_i,
    output x_o, busy, done, pass, fail_count, cex_valid, cex_x, cex_y
  );

endinterface

// File: rtl/skolem_sweep_checker.sv
// Exhaustively sweeps all 2^NX universal inputs, one per cycle, counting phi failures
// and latching the first counterexample (x, y).
module skolem_sweep_checker
  import skolem_pkg::*;
#(
  parameter int NX = SKOLEM_NX,
  parameter int NY = SKOLEM_NY
) (
  input logic                   clk,
  input logic                   rst,
  skolem_sweep_checker_if.slave bus
);

  localparam logic [NX-1:0] X_LAST    = {NX{1'b1}};
  localparam logic [NX-1:0] X_ZERO    = {NX{1'b0}};
  localparam logic [NX-1:0] X_ONE     = {{(NX-1){1'b0}}, 1'b1};
  localparam logic [NX:0]   FAIL_MAX  = {1'b1, {NX{1'b0}}};
  localparam logic [NX:0]   FAIL_ZERO = {(NX+1){1'b0}};
  localparam logic [NX:0]   FAIL_ONE  = {{NX{1'b0}}, 1'b1};
  localparam logic [NY-1:0] Y_ZERO    = {NY{1'b0}};

  state_t        state_r, next_state_s;
  logic [NX-1:0] x_r, x_s;
  logic [NX:0]   fail_count_r, fail_count_s;
  logic          cex_valid_r, cex_valid_s;
  logic [NX-1:0] cex_x_r, cex_x_s;
  logic [NY-1:0] cex_y_r, cex_y_s;
  logic          pass_r, pass_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; abort beats start in IDLE and ends a running sweep.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (bus.abort) begin
          next_state_s = IDLE;
        end else if (x_r == X_LAST) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output/datapath next values; every output is registered from these.
  always_comb begin
    x_s          = x_r;
    fail_count_s = fail_count_r;
    cex_valid_s  = cex_valid_r;
    cex_x_s      = cex_x_r;
    cex_y_s      = cex_y_r;
    pass_s       = pass_r;
    busy_s       = (next_state_s == RUN);
    done_s       = (next_state_s == DONE);
    case (state_r)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          x_s          = X_ZERO;
          fail_count_s = FAIL_ZERO;
          cex_valid_s  = 1'b0;
          pass_s       = 1'b0;
        end else begin
          x_s = x_r;
        end
      end
      RUN: begin
        if (bus.abort) begin
          pass_s = 1'b0;
        end else begin
          if (!bus.phi_i) begin
            if (fail_count_r != FAIL_MAX) begin
              fail_count_s = fail_count_r + FAIL_ONE;
            end else begin
              fail_count_s = fail_count_r;
            end
            if (!cex_valid_r) begin
              cex_valid_s = 1'b1;
              cex_x_s     = x_r;
              cex_y_s     = bus.y_i;
            end else begin
              cex_valid_s = cex_valid_r;
            end
          end else begin
            fail_count_s = fail_count_r;
          end
          // The verdict is taken on the last vector's edge so it is valid alongside done.
          if (x_r != X_LAST) begin
            x_s = x_r + X_ONE;
          end else begin
            x_s    = x_r;
            pass_s = (fail_count_s == FAIL_ZERO);
          end
        end
      end
      DONE:    x_s = x_r;
      default: x_s = x_r;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r          <= X_ZERO;
      fail_count_r <= FAIL_ZERO;
      cex_valid_r  <= 1'b0;
      cex_x_r      <= X_ZERO;
      cex_y_r      <= Y_ZERO;
      pass_r       <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      x_r          <= x_s;
      fail_count_r <= fail_count_s;
      cex_valid_r  <= cex_valid_s;
      cex_x_r      <= cex_x_s;
      cex_y_r      <= cex_y_s;
      pass_r       <= pass_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  assign bus.x_o        = x_r;
  assign bus.fail_count = fail_count_r;
  assign bus.cex_valid  = cex_valid_r;
  assign bus.cex_x      = cex_x_r;
  assign bus.cex_y      = cex_y_r;
  assign bus.pass       = pass_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Directed bench: a table of full sweeps against a small Skolem/phi model, plus
// hand-written abort, reset and held-start sequences.
module tb_skolem_sweep_checker;
  import skolem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  // 0: correct, 1: wrong y at fx, 2: phi always 0, 3: phi fails for x >= fx
  logic [1:0] mode = 2'd0;
  logic [4:0] fx   = 5'd0;

  skolem_sweep_checker_if #(.NX(5), .NY(3)) bus ();

  skolem_sweep_checker #(.NX(5), .NY(3)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] f_sk(input logic [4:0] x);
    return x[2:0] + {1'b0, x[4:3]};
  endfunction

  // Skolem function and phi predicate sitting beside the checker.
  always_comb begin
    logic [2:0] y;
    y = f_sk(bus.x_o);
    if (mode == 2'd1 && bus.x_o == fx) y = 3'b101;
    bus.y_i   = y;
    bus.phi_i = (y == f_sk(bus.x_o)) && (mode != 2'd2) && !(mode == 2'd3 && bus.x_o >= fx);
  end

  typedef struct {
    logic [1:0] mode;
    logic [4:0] fx;
    logic [5:0] exp_fail;
    logic       exp_pass;
    logic       exp_cv;
    logic [4:0] exp_cx;
    logic [2:0] exp_cy;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic start_only(input string tag);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, ".busy_at_start"}, bus.busy, 1);
    check({tag, ".x_at_start"}, bus.x_o, 0);
    check({tag, ".cv_at_start"}, bus.cex_valid, 0);
  endtask

  task automatic finish_sweep(input string tag);
    int cnt;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, ".run_cycles"}, cnt, 32);
    check({tag, ".done_pulse"}, bus.done, 1);
  endtask

  task automatic wait_x(input string tag, input logic [4:0] t);
    int cnt;
    cnt = 0;
    while (bus.x_o !== t && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, ".reached_x"}, bus.x_o, {27'd0, t});
  endtask

  initial begin
    vecs[0] = '{2'd0, 5'd0,  6'd0,  1'b1, 1'b0, 5'd0,  3'd0};
    vecs[1] = '{2'd1, 5'd7,  6'd1,  1'b0, 1'b1, 5'd7,  3'b101};
    vecs[2] = '{2'd2, 5'd0,  6'd32, 1'b0, 1'b1, 5'd0,  3'd0};
    vecs[3] = '{2'd3, 5'd20, 6'd12, 1'b0, 1'b1, 5'd20, 3'd6};
    vecs[4] = '{2'd3, 5'd31, 6'd1,  1'b0, 1'b1, 5'd31, 3'd2};
    vecs[5] = '{2'd1, 5'd0,  6'd1,  1'b0, 1'b1, 5'd0,  3'b101};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.x", bus.x_o, 0);
    check("rst.busy", bus.busy, 0);
    check("rst.done", bus.done, 0);
    check("rst.pass", bus.pass, 0);
    check("rst.fail", bus.fail_count, 0);
    check("rst.cv", bus.cex_valid, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      mode = vecs[i].mode;
      fx   = vecs[i].fx;
      start_only(tag);
      finish_sweep(tag);
      check({tag, ".pass"}, bus.pass, {31'd0, vecs[i].exp_pass});
      check({tag, ".fail"}, bus.fail_count, {26'd0, vecs[i].exp_fail});
      check({tag, ".cv"}, bus.cex_valid, {31'd0, vecs[i].exp_cv});
      if (vecs[i].exp_cv) begin
        check({tag, ".cx"}, bus.cex_x, {27'd0, vecs[i].exp_cx});
        check({tag, ".cy"}, bus.cex_y, {29'd0, vecs[i].exp_cy});
      end
      check({tag, ".x_last"}, bus.x_o, 31);
      @(negedge clk);
      check({tag, ".done_one_cycle"}, bus.done, 0);
      check({tag, ".pass_hold"}, bus.pass, {31'd0, vecs[i].exp_pass});
    end

    // Abort at x=9 after a failure at x=7.
    mode = 2'd1;
    fx   = 5'd7;
    start_only("abort");
    wait_x("abort", 5'd9);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort.busy", bus.busy, 0);
    check("abort.x_hold", bus.x_o, 9);
    check("abort.pass", bus.pass, 0);
    check("abort.fail_hold", bus.fail_count, 1);
    check("abort.cx_hold", bus.cex_x, 7);
    begin
      int seen_done;
      seen_done = 0;
      for (int k = 0; k < 3; k++) begin
        if (bus.done === 1'b1) seen_done++;
        @(negedge clk);
      end
      check("abort.no_done", seen_done, 0);
    end
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_wins.busy", bus.busy, 0);
    check("abort_wins.x", bus.x_o, 9);
    mode = 2'd0;
    start_only("restart");
    finish_sweep("restart");
    check("restart.pass", bus.pass, 1);

    // Reset at x=20 with one failure latched; start alongside rst is ignored.
    mode = 2'd1;
    fx   = 5'd7;
    start_only("rst_mid");
    wait_x("rst_mid", 5'd20);
    check("rst_mid.cv_before", bus.cex_valid, 1);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    check("rst_mid.x", bus.x_o, 0);
    check("rst_mid.busy", bus.busy, 0);
    check("rst_mid.done", bus.done, 0);
    check("rst_mid.pass", bus.pass, 0);
    check("rst_mid.fail", bus.fail_count, 0);
    check("rst_mid.cv", bus.cex_valid, 0);
    check("rst_mid.cx", bus.cex_x, 0);
    check("rst_mid.cy", bus.cex_y, 0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_mid.start_ignored", bus.busy, 0);

    // Start held through a whole sweep.
    mode = 2'd0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    check("held.busy", bus.busy, 1);
    finish_sweep("held");
    @(negedge clk);
    check("held.idle_busy", bus.busy, 0);
    check("held.idle_done", bus.done, 0);
    @(negedge clk);
    bus.start = 1'b0;
    check("held.restart_busy", bus.busy, 1);
    check("held.restart_x", bus.x_o, 0);
    finish_sweep("held2");
    check("held2.pass", bus.pass, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/skolem_sweep_checker.md
SKOLEM_SWEEP_CHECKER -- requirements
Module: skolem_sweep_checker

Interface
REQ-001 Parameter NX, default 5: number of universal inputs driven to the Skolem function.
REQ-002 Parameter NY, default 3: number of Skolem outputs returned.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 start  in  1  begin a sweep; honoured only in IDLE.
REQ-006 abort  in  1  cancel a running sweep.
REQ-007 x_o  out  NX  current input vector to the Skolem function, registered.
REQ-008 y_i  in  NY  Skolem outputs for x_o, combinational from x_o.
REQ-009 phi_i  in  1  spec formula evaluated on (x_o, y_i); 1 means satisfied.
REQ-010 busy  out  1  high in RUN.
REQ-011 done  out  1  one-cycle pulse when a sweep completes.
REQ-012 pass  out  1  result of the last completed sweep.
REQ-013 fail_count  out  NX+1  vectors with phi_i=0 in the current or last sweep.
REQ-014 cex_valid  out  1  a counterexample is latched.
REQ-015 cex_x  out  NX  first failing input vector.
REQ-016 cex_y  out  NY  y_i captured with cex_x.

Function
REQ-017 States SHALL be IDLE, RUN and DONE.
REQ-018 In IDLE with start=1 and abort=0, the next state SHALL be RUN. On that edge: x_o=0, fail_count=0, cex_valid=0, pass=0.
REQ-019 In RUN, each cycle SHALL evaluate phi_i for the x_o currently held, one vector per cycle, with no gaps.
REQ-020 In RUN with phi_i=0, fail_count SHALL increment. If cex_valid=0, cex_x<=x_o, cex_y<=y_i and cex_valid<=1 on the same edge.
REQ-021 In RUN with x_o below 2^NX-1, x_o SHALL increment. At x_o=2^NX-1, x_o SHALL hold and the next state SHALL be DONE.
REQ-022 The sweep SHALL take exactly 2^NX RUN cycles.
REQ-023 In DONE, done=1 for exactly one cycle and pass=(fail_count==0). The next state SHALL be IDLE.
REQ-024 pass, fail_count, cex_* and x_o SHALL hold their values in IDLE until the next accepted start.
REQ-025 abort=1 in RUN SHALL force the next state to IDLE. done is not pulsed, pass=0, and fail_count and cex_* hold their partial values.
REQ-026 start and abort together in IDLE: abort SHALL win and the state SHALL remain IDLE.
REQ-027 start in RUN or DONE SHALL be ignored.
REQ-028 The counter SHALL NOT wrap, and fail_count SHALL saturate at 2^NX, which is representable in NX+1 bits.

Reset
REQ-029 rst=1 SHALL force IDLE and clear x_o, busy, done, pass, fail_count, cex_valid, cex_x and cex_y to 0 on the next edge, including mid-sweep.
REQ-030 rst SHALL take priority over start and abort.

Structure
REQ-031 Package skolem_pkg SHALL hold the NX and NY defaults and the state enum (IDLE, RUN, DONE).
REQ-032 No sub-module SHALL be used. The Skolem function and the phi predicate are instantiated beside this block by the test top.
REQ-033 Only y_i and phi_i SHALL be combinational inputs. All outputs SHALL be registered.

Verification
REQ-034 Correct Skolem function with phi = spec formula; start pulsed one cycle after rst release -> busy for 32 cycles, done pulse one cycle later, pass=1, fail_count=0, cex_valid=0.
REQ-035 phi_i forced to 0 only when x_o=5'd7, with y_i=3'b101 -> fail_count=1, cex_x=5'd7, cex_y=3'b101, pass=0.
REQ-036 phi_i tied to 0 -> fail_count=6'd32, cex_x=0, pass=0, done pulses after 32 RUN cycles.
REQ-037 abort asserted while x_o=5'd9 -> IDLE next cycle, no done pulse, pass=0, x_o holds 9. A subsequent start restarts at x_o=0.
REQ-038 rst asserted at x_o=5'd20 with one failure latched -> all outputs 0 next cycle. start asserted together with rst is ignored.
REQ-039 start held high through an entire sweep -> no restart while busy. A new sweep begins the cycle after DONE returns to IDLE.
